// File: rtl/mem_stack_sequencer.sv
// mem_stack_sequencer: memory-stage stack controller.
// Owns the stack pointer and sequences multi-beat stack traffic through the
// shared data memory port. A 32-bit PC moves as two 16-bit beats, and an
// interrupt adds a flags beat. Popped PC, flags and data words are returned
// to writeback/fetch.
//
// Optional build macro: STACK_GUARD_EN
//   When it is defined, requests that would underflow or overflow the stack
//   are rejected in IDLE and raise the sticky stack_err flag.
//   When it is undefined, there are no checks, stack_err is 0 and SP wraps.
//
// Request handshake (op_valid / stall):
//   A request is taken in IDLE in the same cycle that op_valid=1 carries a
//   legal op (1..6). stall is asserted combinationally in that acceptance
//   cycle and stays high through the last beat. The requester must hold
//   op_valid/op until it sees stall low. op_valid seen while busy is ignored.

module mem_stack_sequencer #(
   parameter int           W        = 16,
   parameter logic [W-1:0] SP_RESET = 16'h07FF,
   parameter logic [W-1:0] SP_LIMIT = 16'h0000
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           op_valid,
   input  logic [2:0]     op,
   input  logic [W-1:0]   RD,
   output logic           MEM_READ,
   output logic           MEM_WRITE,
   output logic [1:0]     MEM_ADDR_SEL,
   output logic [2:0]     MEM_DATA_SEL,
   output logic [W-1:0]   sp,
   output logic           stall,
   output logic           busy,
   output logic [W-1:0]   pop_data,
   output logic           pop_valid,
   output logic [2*W-1:0] pc_out,
   output logic           pc_valid,
   output logic [2:0]     flags_out,
   output logic           flags_valid,
   output logic           stack_err,
   output logic [3:0]     state_dbg
);

   // Operation encodings on op
   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_PUSH = 3'd1;
   localparam logic [2:0] OP_POP  = 3'd2;
   localparam logic [2:0] OP_CALL = 3'd3;
   localparam logic [2:0] OP_RET  = 3'd4;
   localparam logic [2:0] OP_INT  = 3'd5;
   localparam logic [2:0] OP_RTI  = 3'd6;
   localparam logic [2:0] OP_RSV  = 3'd7;

   // Address mux selects
   localparam logic [1:0] ASEL_RSRC = 2'd0;
   localparam logic [1:0] ASEL_SP   = 2'd3;

   // Data mux selects
   localparam logic [2:0] DSEL_RDST    = 3'd1;
   localparam logic [2:0] DSEL_FLAGS   = 3'd2;
   localparam logic [2:0] DSEL_PC_HI   = 3'd3;
   localparam logic [2:0] DSEL_PC_LO   = 3'd4;
   localparam logic [2:0] DSEL_PCP_HI  = 3'd5;
   localparam logic [2:0] DSEL_PCP_LO  = 3'd6;
   localparam logic [2:0] DSEL_ZERO    = 3'd7;

   localparam logic [W-1:0] SP_ONE = {{(W-1){1'b0}}, 1'b1};

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      PUSH_W  = 4'd1,
      PUSH_HI = 4'd2,
      PUSH_LO = 4'd3,
      PUSH_FL = 4'd4,
      POP_W   = 4'd5,
      POP_FL  = 4'd6,
      POP_LO  = 4'd7,
      POP_HI  = 4'd8
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   sp_q;
   logic [2:0]     op_q;
   logic [W-1:0]   pop_data_q;
   logic [2*W-1:0] pc_q;
   logic [2:0]     flags_q;
   logic           pop_valid_q;
   logic           pc_valid_q;
   logic           flags_valid_q;

   logic           op_legal;
   logic           reject;
   logic           accept;
   logic           is_int;

   assign op_legal = op_valid && (op != OP_NOP) && (op != OP_RSV);
   assign is_int   = (op_q == OP_INT);

`ifdef STACK_GUARD_EN
   logic [1:0]   n_push;
   logic [1:0]   n_pop;
   logic [W+1:0] sp_x;
   logic [W+1:0] limit_x;
   logic [W+1:0] top_x;
   logic [W+1:0] n_push_x;
   logic [W+1:0] n_pop_x;
   logic         err_q;

   // Words each request would push or pop, used to check the stack bounds
   always_comb begin
      n_push = 2'd0;
      n_pop  = 2'd0;
      case (op)
         OP_PUSH: n_push = 2'd1;
         OP_CALL: n_push = 2'd2;
         OP_INT:  n_push = 2'd3;
         OP_POP:  n_pop  = 2'd1;
         OP_RET:  n_pop  = 2'd2;
         OP_RTI:  n_pop  = 2'd3;
         default: ;
      endcase
   end

   // The comparisons are widened by two bits so that wrap-around cannot hide a violation
   assign sp_x     = {2'b00, sp_q};
   assign limit_x  = {2'b00, SP_LIMIT};
   assign top_x    = {2'b00, SP_RESET};
   assign n_push_x = {{W{1'b0}}, n_push};
   assign n_pop_x  = {{W{1'b0}}, n_pop};

   // Reject when the lowest written word is below SP_LIMIT, or when SP would rise above SP_RESET
   assign reject = op_legal &&
                   (((sp_x + {{(W+1){1'b0}}, 1'b1}) < (limit_x + n_push_x)) ||
                    ((sp_x + n_pop_x) > top_x));

   // Sticky error flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst)
         err_q <= 1'b0;
      else if ((state_q == IDLE) && reject)
         err_q <= 1'b1;
   end

   assign stack_err = err_q;
`else
   logic unused_limit;
   assign unused_limit = ^SP_LIMIT;
   assign reject       = 1'b0;
   assign stack_err    = 1'b0;
`endif

   // Next-state and beat decode: memory strobes, mux selects and the stack address
   always_comb begin
      state_d      = state_q;
      accept       = 1'b0;
      MEM_READ     = 1'b0;
      MEM_WRITE    = 1'b0;
      MEM_ADDR_SEL = ASEL_RSRC;
      MEM_DATA_SEL = DSEL_ZERO;
      sp           = sp_q;
      case (state_q)
         IDLE: begin
            if (op_legal && !reject) begin
               accept = 1'b1;
               case (op)
                  OP_PUSH:         state_d = PUSH_W;
                  OP_POP:          state_d = POP_W;
                  OP_CALL, OP_INT: state_d = PUSH_HI;
                  OP_RET:          state_d = POP_LO;
                  OP_RTI:          state_d = POP_FL;
                  default:         state_d = IDLE;
               endcase
            end
         end
         PUSH_W: begin
            MEM_WRITE    = 1'b1;
            MEM_ADDR_SEL = ASEL_SP;
            MEM_DATA_SEL = DSEL_RDST;
            state_d      = IDLE;
         end
         PUSH_HI: begin
            MEM_WRITE    = 1'b1;
            MEM_ADDR_SEL = ASEL_SP;
            MEM_DATA_SEL = is_int ? DSEL_PC_HI : DSEL_PCP_HI;
            state_d      = PUSH_LO;
         end
         PUSH_LO: begin
            MEM_WRITE    = 1'b1;
            MEM_ADDR_SEL = ASEL_SP;
            MEM_DATA_SEL = is_int ? DSEL_PC_LO : DSEL_PCP_LO;
            state_d      = is_int ? PUSH_FL : IDLE;
         end
         PUSH_FL: begin
            MEM_WRITE    = 1'b1;
            MEM_ADDR_SEL = ASEL_SP;
            MEM_DATA_SEL = DSEL_FLAGS;
            state_d      = IDLE;
         end
         POP_W: begin
            MEM_READ     = 1'b1;
            MEM_ADDR_SEL = ASEL_SP;
            sp           = sp_q + SP_ONE;
            state_d      = IDLE;
         end
         POP_FL: begin
            MEM_READ     = 1'b1;
            MEM_ADDR_SEL = ASEL_SP;
            sp           = sp_q + SP_ONE;
            state_d      = POP_LO;
         end
         POP_LO: begin
            MEM_READ     = 1'b1;
            MEM_ADDR_SEL = ASEL_SP;
            sp           = sp_q + SP_ONE;
            state_d      = POP_HI;
         end
         POP_HI: begin
            MEM_READ     = 1'b1;
            MEM_ADDR_SEL = ASEL_SP;
            sp           = sp_q + SP_ONE;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register, latched op, and stack pointer (post-decrement on push, pre-increment on pop)
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_NOP;
         sp_q    <= SP_RESET;
      end else begin
         state_q <= state_d;
         if (accept)
            op_q <= op;
         if (MEM_WRITE)
            sp_q <= sp_q - SP_ONE;
         else if (MEM_READ)
            sp_q <= sp_q + SP_ONE;
      end
   end

   // Capture popped words; the result pulses rise for one cycle after the final pop beat
   always_ff @(posedge clk) begin
      if (rst) begin
         pop_data_q    <= '0;
         pc_q          <= '0;
         flags_q       <= 3'b000;
         pop_valid_q   <= 1'b0;
         pc_valid_q    <= 1'b0;
         flags_valid_q <= 1'b0;
      end else begin
         pop_valid_q   <= 1'b0;
         pc_valid_q    <= 1'b0;
         flags_valid_q <= 1'b0;
         case (state_q)
            POP_W: begin
               pop_data_q  <= RD;
               pop_valid_q <= 1'b1;
            end
            POP_FL: flags_q <= RD[2:0];
            POP_LO: pc_q[W-1:0] <= RD;
            POP_HI: begin
               pc_q[2*W-1:W] <= RD;
               pc_valid_q    <= 1'b1;
               flags_valid_q <= (op_q == OP_RTI);
            end
            default: ;
         endcase
      end
   end

   assign busy        = (state_q != IDLE);
   assign stall       = busy | accept;
   assign pop_data    = pop_data_q;
   assign pop_valid   = pop_valid_q;
   assign pc_out      = pc_q;
   assign pc_valid    = pc_valid_q;
   assign flags_out   = flags_q;
   assign flags_valid = flags_valid_q;
   assign state_dbg   = state_q;

endmodule

// File: doc/mem_stack_sequencer.md
Name: mem_stack_sequencer

Overview:
- Memory-stage controller that sequences multi-beat stack traffic through the shared data memory port.
- Owns the stack pointer and drives MEM_READ, MEM_WRITE, MEM_ADDR_SEL and MEM_DATA_SEL for the memory-stage address/data muxes.
- Splits 32-bit PC pushes/pops into two 16-bit beats and adds the flags beat for interrupts.
- Holds the pipeline (stall) while a sequence runs; returns popped PC, flags and data words to writeback/fetch.

Parameters:
- W, 16, data/stack-pointer width
- SP_RESET, 16'h07FF, stack pointer value after reset (top of 2K-word memory)
- SP_LIMIT, 16'h0000, lowest legal push address (used only with STACK_GUARD_EN)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- op_valid  in  1  stack operation request
- op  in  3  0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 INT, 6 RTI, 7 reserved (treated as NOP)
- RD  in  W  memory read data, combinationally valid in the cycle MEM_READ is high
- MEM_READ  out  1  memory read strobe
- MEM_WRITE  out  1  memory write strobe
- MEM_ADDR_SEL  out  2  0 Rsrc, 1 Rdst, 2 ALU, 3 sp
- MEM_DATA_SEL  out  3  0 Rsrc, 1 Rdst, 2 flags, 3 pc[31:16], 4 pc[15:0], 5 pc_plus[31:16], 6 pc_plus[15:0], 7 zero
- sp  out  W  stack address presented to the address mux
- stall  out  1  freeze upstream stages
- busy  out  1  sequence in progress
- pop_data  out  W  word popped by POP
- pop_valid  out  1  one-cycle pulse, pop_data valid
- pc_out  out  2W  PC restored by RET/RTI
- pc_valid  out  1  one-cycle pulse, pc_out valid
- flags_out  out  3  flags restored by RTI
- flags_valid  out  1  one-cycle pulse, flags_out valid
- stack_err  out  1  sticky overflow/underflow flag (tied 0 without STACK_GUARD_EN)

Behaviour:
- Reset, applied at the rising edge with rst=1: state IDLE, internal SP=SP_RESET; all strobes, valids, busy and stall = 0; pop_data, pc_out and flags_out = 0; MEM_ADDR_SEL=0, MEM_DATA_SEL=7. Reset mid-sequence abandons the remaining beats; no partial result pulses.
- States: IDLE, PUSH_W, PUSH_HI, PUSH_LO, PUSH_FL, POP_W, POP_FL, POP_LO, POP_HI.
- IDLE: a request is accepted when op_valid=1 and op is 1..6. Next state: PUSH→PUSH_W; POP→POP_W; CALL/INT→PUSH_HI; RET→POP_LO; RTI→POP_FL.
- Beat order: CALL PUSH_HI(sel 5)→PUSH_LO(sel 6); INT PUSH_HI(sel 3)→PUSH_LO(sel 4)→PUSH_FL(sel 2); PUSH PUSH_W(sel 1); RET POP_LO→POP_HI; RTI POP_FL→POP_LO→POP_HI; POP POP_W. The last beat returns to IDLE.
- Push beat: MEM_WRITE=1, MEM_ADDR_SEL=3, sp output = SP; SP ← SP−1 at the edge (post-decrement).
- Pop beat: MEM_READ=1, MEM_ADDR_SEL=3, sp output = SP+1; SP ← SP+1 at the edge (pre-increment); RD captured at the same edge.
- Outside beats: sp output = SP; MEM_READ=MEM_WRITE=0.
- Result registers:
  - POP_LO captures pc_out[15:0]; POP_HI captures pc_out[31:16].
  - POP_FL captures flags_out = RD[2:0]; POP_W captures pop_data.
  - Valid pulses are high for exactly one cycle, the cycle after the final pop beat (flags_valid together with pc_valid for RTI).
- Handshake and stall:
  - busy = (state≠IDLE).
  - stall = busy | (op_valid & accepted op), so stall is high from the acceptance cycle through the last beat cycle inclusive.
  - op_valid while busy is ignored; requesters hold the request until stall drops.
- Latency: CALL/RET 2 beats; INT/RTI 3 beats; PUSH/POP 1 beat. The first beat is issued the cycle after acceptance.
- Arithmetic: SP is W-bit, modulo 2^W (0x0000−1 = 0xFFFF). The memory uses sp[10:0] only.

Optional Feature:
- STACK_GUARD_EN defined:
  - A request is rejected in IDLE (no beats, stall low, stack_err←1) if it would write below SP_LIMIT (SP − pushes + 1 < SP_LIMIT) or raise SP above SP_RESET (SP + pops > SP_RESET).
  - stack_err clears only on rst.
- Undefined: no checks, stack_err=0, SP wraps freely.

Test Plan:
- Reset then CALL, pc_plus=0x1234_5678: write 0x1234 @0x7FF, then 0x5678 @0x7FE; SP=0x7FD; stall high 3 cycles.
- RET after the CALL: reads @0x7FE then @0x7FF; pc_valid pulse with pc_out=0x12345678; SP=0x7FF.
- INT with pc=0xAAAA_BBBB, flags=3'b101: writes 0xAAAA, 0xBBBB, 0x0005 at 0x7FF..0x7FD; then RTI returns flags_out=5 and pc_out=0xAAAABBBB in the same pulse cycle.
- PUSH Rdst=0x00FF, then POP: pop_valid with pop_data=0x00FF; op_valid asserted mid-sequence is ignored (no extra beat).
- rst asserted during the second INT beat: next cycle IDLE, SP=0x7FF, no valid pulses, MEM_WRITE=0.
- STACK_GUARD_EN, POP at SP=0x7FF: no MEM_READ, stack_err=1, SP unchanged; without the macro SP becomes 0x800.
